uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter among `NREQ` byte-producing requesters. It sits in front of the transmitter's `start`/`txin`/`txdone` interface. It picks one pending requester, issues a single-cycle start with that requester's byte, holds the byte stable until the transmitter reports completion, then enforces an idle gap before the next grant. A watchdog recovers the arbiter if the transmitter never signals completion.

---
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Bundle of the requester-side handshake and the transmitter
//               start/data/done signals around uart_tx_arbiter.
//               master : environment view (requesters + UART transmitter)
//               slave  : arbiter view
// Ports       : req[NREQ], req_data[8*NREQ], tx_done      (master -> slave)
//               ack[NREQ], done[NREQ], err, busy,
//               tx_start, tx_data[8]                      (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              err;
  logic              busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;

  modport master (
    output req, req_data, tx_done,
    input  ack, done, err, busy, tx_start, tx_data
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, done, err, busy, tx_start, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter/sequencer sharing one UART transmitter
//               among NREQ byte producers. Grants one requester, issues a
//               one-cycle start with its byte, holds the byte until the
//               transmitter completes (or a watchdog expires), then enforces
//               an idle gap before the next grant. All outputs registered.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - slave modport: req/req_data/tx_done in,
//                        ack/done/err/busy/tx_start/tx_data out
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 20000
) (
  input wire               clk,
  input wire               rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WW-1:0] c_wd_last  = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] c_gap_last = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_gap   = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant;
  logic [WW-1:0]   r_wd_cnt;
  logic [GW-1:0]   r_gap_cnt;

  logic [NREQ-1:0] r_ack,  w_ack_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_err,  w_err_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_tx_start, w_tx_start_nxt;
  logic [7:0]      r_tx_data,  w_tx_data_nxt;

  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic [7:0]      w_sel_byte;
  logic            w_wd_expire;

  // (base + off) mod NREQ without a divider; off is always < NREQ.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin search: first pending requester at or above the pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && bus.req[wrap_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(r_ptr, i);
      end
    end
  end

  assign w_sel_byte  = bus.req_data[{w_sel, 3'b000} +: 8];
  // Counter holds k during the (k+1)-th WAIT cycle, so WAIT lasts TIMEOUT cycles.
  assign w_wd_expire = (r_wd_cnt == c_wd_last);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic. tx_done only matters in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_found) w_state_nxt = c_st_issue;
      c_st_issue: w_state_nxt = c_st_wait;
      c_st_wait: begin
        if (bus.tx_done || w_wd_expire)
          w_state_nxt = (GAP_CYCLES == 0) ? c_st_idle : c_st_gap;
      end
      c_st_gap:   if (r_gap_cnt == c_gap_last) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_ack_nxt      = '0;
    w_done_nxt     = '0;
    w_err_nxt      = 1'b0;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_busy_nxt     = (w_state_nxt != c_st_idle);
    case (r_state)
      c_st_idle: begin
        if (w_found) begin
          w_ack_nxt      = NREQ'(1) << w_sel;
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = w_sel_byte;
        end
      end
      c_st_wait: begin
        // A completion on the expiry cycle still counts as a completion.
        if (bus.tx_done)      w_done_nxt = NREQ'(1) << r_grant;
        else if (w_wd_expire) w_err_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs, grant bookkeeping and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_wd_cnt   <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_ack      <= w_ack_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      if (r_state == c_st_idle && w_found) begin
        r_grant <= w_sel;
        r_ptr   <= wrap_idx(w_sel, 1);
      end
      r_wd_cnt  <= (r_state == c_st_wait) ? r_wd_cnt + WW'(1) : '0;
      r_gap_cnt <= (r_state == c_st_gap)  ? r_gap_cnt + GW'(1) : '0;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.busy     = r_busy;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with
//               NREQ=4, GAP_CYCLES=4, TIMEOUT=64.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int GAP  = 4;
  localparam int TO   = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack1_cnt = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.ack[1] === 1'b1) ack1_cnt <= ack1_cnt + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int budget, output bit ok, output int unsigned at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.tx_start === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called right after tx_start is seen; tx_done is sampled dur edges later.
  task automatic finish_xfer(input int dur);
    repeat (dur - 1) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_data = '0; bus.tx_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({bus.ack, bus.done, bus.err, bus.busy, bus.tx_start, bus.tx_data} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_values: got ack=%b done=%b err=%b busy=%b start=%b data=%h expected all zero",
               bus.ack, bus.done, bus.err, bus.busy, bus.tx_start, bus.tx_data);
    end
    #3 rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_release: got busy=%b start=%b expected 0 0", bus.busy, bus.tx_start);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int unsigned at, prev;
    int e;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      e = i % NREQ;
      wait_start(30, ok, at);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rr_start_%0d: got no tx_start expected start within 30 cycles", i);
      end
      n_tests++;
      if (bus.ack !== 4'(1 << e) || bus.tx_data !== 8'(8'h10 + e)) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got ack=%b data=%h expected ack=%b data=%h",
                 i, bus.ack, bus.tx_data, 4'(1 << e), 8'(8'h10 + e));
      end
      if (i > 0) begin
        n_tests++;
        if (at - prev !== 10) begin
          n_fail++;
          $display("FAIL rr_spacing_%0d: got %0d cycles expected 10", i, at - prev);
        end
      end
      prev = at;
      if (i == 5) bus.req = 4'b0000;
      finish_xfer(5);
      n_tests++;
      if (bus.done !== 4'(1 << e)) begin
        n_fail++;
        $display("FAIL rr_done_%0d: got %b expected %b", i, bus.done, 4'(1 << e));
      end
    end
    wait_idle(20, ok);
  endtask

  task automatic test_single();
    bit ok, stable, early;
    bus.req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    bus.req = 4'b0100;
    tick();
    n_tests++;
    if (bus.tx_start !== 1'b1 || bus.ack !== 4'b0100 || bus.tx_data !== 8'hA5 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got start=%b ack=%b data=%h busy=%b expected 1 0100 a5 1",
               bus.tx_start, bus.ack, bus.tx_data, bus.busy);
    end
    bus.req = 4'b0000;
    tick();
    n_tests++;
    if (bus.tx_start !== 1'b0 || bus.ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_pulse_width: got start=%b ack=%b expected 0 0000", bus.tx_start, bus.ack);
    end
    stable = 1'b1; early = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (bus.tx_data !== 8'hA5) stable = 1'b0;
      if (bus.done !== 4'b0000 || bus.err !== 1'b0) early = 1'b1;
    end
    n_tests++;
    if (!stable || early) begin
      n_fail++;
      $display("FAIL single_wait_hold: got stable=%b early_event=%b expected 1 0", stable, early);
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n_tests++;
    if (bus.done !== 4'b0100 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got done=%b err=%b expected 0100 0", bus.done, bus.err);
    end
    tick();
    n_tests++;
    if (bus.done !== 4'b0000 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gap_start: got done=%b busy=%b expected 0000 1", bus.done, bus.busy);
    end
    repeat (2) tick();
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gap_busy: got busy=%b expected 1", bus.busy);
    end
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b data=%h expected 0 a5", bus.busy, bus.tx_data);
    end
    wait_idle(5, ok);
  endtask

  task automatic test_skip_wrap();
    bit ok;
    int unsigned at;
    logic [3:0] exp_ack [3];
    exp_ack[0] = 4'b1000; exp_ack[1] = 4'b0001; exp_ack[2] = 4'b0010;
    bus.req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    bus.req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      wait_start(30, ok, at);
      n_tests++;
      if (!ok || bus.ack !== exp_ack[i]) begin
        n_fail++;
        $display("FAIL skip_wrap_%0d: got ok=%b ack=%b expected 1 %b", i, ok, bus.ack, exp_ack[i]);
      end
      bus.req = (i == 0) ? 4'b0011 : ((i == 1) ? 4'b0010 : 4'b0000);
      finish_xfer(3);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_watchdog();
    bit ok, got, saw_done;
    int unsigned s, errcyc;
    bus.req = 4'b0001;
    wait_start(30, ok, s);
    bus.req = 4'b0000;
    got = 1'b0; saw_done = 1'b0; errcyc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.done !== 4'b0000) saw_done = 1'b1;
      if (bus.err === 1'b1) begin
        got = 1'b1;
        errcyc = cyc;
        break;
      end
    end
    n_tests++;
    if (!got || errcyc - (s + 1) !== TO) begin
      n_fail++;
      $display("FAIL wd_err_timing: got seen=%b at %0d cycles after WAIT entry expected 1 at %0d",
               got, errcyc - (s + 1), TO);
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL wd_no_done: got done pulse expected none");
    end
    tick();
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_err_width: got err=%b expected 0", bus.err);
    end
    wait_idle(20, ok);
    bus.req = 4'b0010;
    wait_start(30, ok, s);
    n_tests++;
    if (!ok || bus.ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL wd_recover_grant: got ok=%b ack=%b expected 1 0010", ok, bus.ack);
    end
    bus.req = 4'b0000;
    finish_xfer(4);
    n_tests++;
    if (bus.done !== 4'b0010) begin
      n_fail++;
      $display("FAIL wd_recover_done: got %b expected 0010", bus.done);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_edge_events();
    bit ok, early;
    int unsigned s;
    int ack1_before;
    // tx_done during the start cycle must be ignored.
    bus.req = 4'b0100;
    wait_start(30, ok, s);
    bus.req = 4'b0000;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n_tests++;
    if (bus.done !== 4'b0000 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_on_start_ignored: got done=%b busy=%b expected 0000 1", bus.done, bus.busy);
    end
    repeat (2) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n_tests++;
    if (bus.done !== 4'b0100) begin
      n_fail++;
      $display("FAIL still_waiting_done: got %b expected 0100", bus.done);
    end
    wait_idle(20, ok);

    // tx_done on the watchdog expiry cycle wins.
    bus.req = 4'b1000;
    wait_start(30, ok, s);
    bus.req = 4'b0000;
    early = 1'b0;
    while (cyc < s + TO) begin
      tick();
      if (bus.err !== 1'b0 || bus.done !== 4'b0000) early = 1'b1;
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n_tests++;
    if (early || bus.done !== 4'b1000 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL done_beats_expiry: got early=%b done=%b err=%b expected 0 1000 0",
               early, bus.done, bus.err);
    end
    tick();
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_late_err: got err=%b expected 0", bus.err);
    end
    wait_idle(20, ok);

    // Requester 1 withdraws before its turn: no ack, next pending wins.
    ack1_before = ack1_cnt;
    bus.req = 4'b0001;
    wait_start(30, ok, s);
    bus.req = 4'b0010;
    repeat (2) tick();
    bus.req = 4'b0100;
    finish_xfer(4);
    wait_start(30, ok, s);
    n_tests++;
    if (!ok || bus.ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL dropped_req_skip: got ok=%b ack=%b expected 1 0100", ok, bus.ack);
    end
    bus.req = 4'b0000;
    finish_xfer(4);
    wait_idle(20, ok);
    n_tests++;
    if (ack1_cnt !== ack1_before) begin
      n_fail++;
      $display("FAIL dropped_req_no_ack: got %0d acks expected 0", ack1_cnt - ack1_before);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, spur;
    int unsigned s;
    bus.req_data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
    bus.req = 4'b0100;
    wait_start(30, ok, s);
    bus.req = 4'b0000;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.ack, bus.done, bus.err, bus.busy, bus.tx_start, bus.tx_data} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_async_clear: got ack=%b done=%b err=%b busy=%b start=%b data=%h expected all zero",
               bus.ack, bus.done, bus.err, bus.busy, bus.tx_start, bus.tx_data);
    end
    repeat (2) tick();
    #3 rst_n = 1'b1;
    spur = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done !== 4'b0000 || bus.err !== 1'b0 || bus.busy !== 1'b0) spur = 1'b1;
    end
    n_tests++;
    if (spur) begin
      n_fail++;
      $display("FAIL reset_no_residue: got done/err/busy activity expected none");
    end
    bus.req = 4'b1000;
    wait_start(30, ok, s);
    n_tests++;
    if (!ok || bus.ack !== 4'b1000 || bus.tx_data !== 8'hE3) begin
      n_fail++;
      $display("FAIL post_reset_grant3: got ok=%b ack=%b data=%h expected 1 1000 e3", ok, bus.ack, bus.tx_data);
    end
    bus.req = 4'b1111;
    finish_xfer(3);
    wait_start(30, ok, s);
    n_tests++;
    if (!ok || bus.ack !== 4'b0001 || bus.tx_data !== 8'hE0) begin
      n_fail++;
      $display("FAIL post_reset_grant0: got ok=%b ack=%b data=%h expected 1 0001 e0", ok, bus.ack, bus.tx_data);
    end
    bus.req = 4'b0000;
    finish_xfer(3);
    wait_idle(20, ok);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_skip_wrap();
    test_watchdog();
    test_edge_events();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
